// File: rtl/alu_wb_stage.sv
// ALU write-back stage: 2-entry skid FIFO between execute and the register file,
// plus the architectural status register and a saturating overflow counter.
module alu_wb_stage (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_result,
   input  logic [31:0] in_overf,
   input  logic [3:0]  in_flags,
   input  logic [4:0]  in_dest,
   input  logic        in_wen,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [63:0] wb_data,
   output logic [4:0]  wb_addr,
   input  logic        flag_clr,
   output logic [7:0]  status,
   output logic [15:0] ovf_count
);

   // Flag bit positions inside the 4-bit ALU flag vector.
   localparam int unsigned FLAG_ZERO = 0;
   localparam int unsigned FLAG_CMP  = 1;
   localparam int unsigned FLAG_PAR  = 2;
   localparam int unsigned FLAG_OVF  = 3;
   localparam int unsigned DEPTH     = 2;

   typedef struct packed {
      logic [63:0] result;
      logic [31:0] overf;
      logic [3:0]  flags;
      logic [4:0]  dest;
      logic        wen;
   } entry_t;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

   occ_e        occ_q;
   logic        in_ready_q;
   logic        wr_ptr_q;
   logic        rd_ptr_q;
   entry_t      in_entry;
   entry_t      slot_vec [DEPTH];
   entry_t      head;
   logic        has_head;
   logic        push;
   logic        pop;
   logic        head_ovf;
   logic [3:0]  stat_lo_q;
   logic [3:0]  stat_lo_d;
   logic        sticky_q;
   logic [15:0] ovf_cnt_q;
   logic [15:0] ovf_cnt_inc;

   assign in_entry = '{
      result: in_result,
      overf:  in_overf,
      flags:  in_flags,
      dest:   in_dest,
      wen:    in_wen
   };

   always_comb begin
      head     = slot_vec[rd_ptr_q];
      has_head = (occ_q != OCC_EMPTY);
      push     = in_valid & in_ready_q;
      // Flags-only entries retire without waiting on the register file.
      pop      = has_head & (~head.wen | wb_ready);
      head_ovf = head.flags[FLAG_OVF] | (|head.overf);
   end

   // Occupancy FSM; in_ready is registered so it never depends on wb_ready.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         occ_q      <= OCC_EMPTY;
         in_ready_q <= 1'b1;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop)  rd_ptr_q <= ~rd_ptr_q;
         case (occ_q)
            OCC_EMPTY: begin
               if (push) occ_q <= OCC_ONE;
            end
            OCC_ONE: begin
               if (push && !pop) begin
                  occ_q      <= OCC_FULL;
                  in_ready_q <= 1'b0;
               end else if (pop && !push) begin
                  occ_q <= OCC_EMPTY;
               end
            end
            OCC_FULL: begin
               if (pop) begin
                  occ_q      <= OCC_ONE;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               occ_q      <= OCC_EMPTY;
               in_ready_q <= 1'b1;
            end
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
         entry_t slot_q;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               slot_q <= '0;
            end else if (push && (wr_ptr_q == 1'(gi))) begin
               slot_q <= in_entry;
            end
         end

         assign slot_vec[gi] = slot_q;
      end
   endgenerate

   assign stat_lo_d   = {~head.flags[FLAG_PAR], head.flags[FLAG_PAR],
                         head.flags[FLAG_CMP], head.flags[FLAG_ZERO]};
   assign ovf_cnt_inc = (&ovf_cnt_q) ? ovf_cnt_q : ovf_cnt_q + 16'd1;

   // A retiring overflow beats a simultaneous clear, leaving a count of one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_lo_q <= 4'b1000;
         sticky_q  <= 1'b0;
         ovf_cnt_q <= '0;
      end else begin
         if (pop) stat_lo_q <= stat_lo_d;
         if (pop && head_ovf) begin
            sticky_q  <= 1'b1;
            ovf_cnt_q <= flag_clr ? 16'd1 : ovf_cnt_inc;
         end else if (flag_clr) begin
            sticky_q  <= 1'b0;
            ovf_cnt_q <= '0;
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign wb_valid  = has_head & head.wen;
   assign wb_data   = has_head ? head.result : '0;
   assign wb_addr   = has_head ? head.dest : '0;
   assign status    = {3'b000, sticky_q, stat_lo_q};
   assign ovf_count = ovf_cnt_q;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Directed bench for alu_wb_stage: queue-based reference model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_alu_wb_stage;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_result = '0;
   logic [31:0] in_overf = '0;
   logic [3:0]  in_flags = '0;
   logic [4:0]  in_dest = '0;
   logic        in_wen = 1'b0;
   logic        wb_valid;
   logic        wb_ready = 1'b1;
   logic [63:0] wb_data;
   logic [4:0]  wb_addr;
   logic        flag_clr = 1'b0;
   logic [7:0]  status;
   logic [15:0] ovf_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] result;
      logic [31:0] overf;
      logic [3:0]  flags;
      logic [4:0]  dest;
      logic        wen;
   } mentry_t;

   mentry_t     mq[$];
   logic [3:0]  m_lo = 4'b1000;
   logic        m_sticky = 1'b0;
   int          m_cnt = 0;
   logic [68:0] wlog[$];

   alu_wb_stage dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_result (in_result),
      .in_overf  (in_overf),
      .in_flags  (in_flags),
      .in_dest   (in_dest),
      .in_wen    (in_wen),
      .wb_valid  (wb_valid),
      .wb_ready  (wb_ready),
      .wb_data   (wb_data),
      .wb_addr   (wb_addr),
      .flag_clr  (flag_clr),
      .status    (status),
      .ovf_count (ovf_count)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model: a plain queue plus status bits, updated from the rules.
   initial forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
         mq.delete();
         m_lo     = 4'b1000;
         m_sticky = 1'b0;
         m_cnt    = 0;
      end else begin
         bit      do_pop;
         bit      do_push;
         bit      ovf;
         mentry_t e;
         do_pop  = (mq.size() > 0) && (!mq[0].wen || wb_ready);
         do_push = in_valid && (mq.size() < 2);
         ovf     = 1'b0;
         if (do_pop) begin
            e    = mq.pop_front();
            m_lo = {~e.flags[2], e.flags[2], e.flags[1], e.flags[0]};
            ovf  = e.flags[3] || (e.overf != 0);
         end
         if (ovf) begin
            m_sticky = 1'b1;
            m_cnt    = flag_clr ? 1 : ((m_cnt < 65535) ? m_cnt + 1 : 65535);
         end else if (flag_clr) begin
            m_sticky = 1'b0;
            m_cnt    = 0;
         end
         if (do_push)
            mq.push_back('{result: in_result, overf: in_overf, flags: in_flags,
                           dest: in_dest, wen: in_wen});
      end
   end

   // Per-cycle comparison against the model, sampled on the falling edge.
   initial forever begin
      bit exp_valid;
      @(negedge clk);
      exp_valid = reset_n && (mq.size() > 0) && mq[0].wen;
      chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
      chk("wb_valid", 64'(wb_valid), 64'(exp_valid));
      chk("status", 64'(status), 64'({3'b000, m_sticky, m_lo}));
      chk("ovf_count", 64'(ovf_count), 64'(m_cnt));
      if (exp_valid) begin
         chk("wb_data", wb_data, mq[0].result);
         chk("wb_addr", 64'(wb_addr), 64'(mq[0].dest));
      end
      if (reset_n && wb_valid && wb_ready) begin
         wlog.push_back({wb_addr, wb_data});
         $display("write addr=%0d data=%0h", wb_addr, wb_data);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [63:0] r, input logic [31:0] o, input logic [3:0] f,
                        input logic [4:0] d, input logic w);
      in_valid  = 1'b1;
      in_result = r;
      in_overf  = o;
      in_flags  = f;
      in_dest   = d;
      in_wen    = w;
   endtask

   initial begin
      int n;

      // Reset state
      repeat (3) step();
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_wb_valid", 64'(wb_valid), 64'd0);
      chk("rst_wb_data", wb_data, 64'd0);
      chk("rst_wb_addr", 64'(wb_addr), 64'd0);
      chk("rst_status", 64'(status), 64'h08);
      chk("rst_ovf_count", 64'(ovf_count), 64'd0);
      reset_n = 1'b1;
      step();

      // Simple write, one-cycle latency
      wb_ready = 1'b1;
      drive(64'h5, 32'h0, 4'h0, 5'd3, 1'b1);
      step();
      in_valid = 1'b0;
      $display("txn simple write pushed");
      chk("simple_wb_valid", 64'(wb_valid), 64'd1);
      chk("simple_wb_data", wb_data, 64'h5);
      chk("simple_wb_addr", 64'(wb_addr), 64'd3);
      step();
      chk("simple_status", 64'(status), 64'h08);
      chk("simple_wb_valid_after", 64'(wb_valid), 64'd0);

      // Back-pressure: three back-to-back entries
      wlog.delete();
      wb_ready = 1'b0;
      drive(64'hA0A0, 32'h0, 4'h0, 5'd1, 1'b1);
      step();
      chk("bp_ready_after_a", 64'(in_ready), 64'd1);
      drive(64'hB0B0, 32'h0, 4'h0, 5'd2, 1'b1);
      step();
      chk("bp_ready_after_b", 64'(in_ready), 64'd0);
      drive(64'hC0C0, 32'h0, 4'h0, 5'd3, 1'b1);
      step();
      chk("bp_ready_c_held", 64'(in_ready), 64'd0);
      chk("bp_head_stable", 64'(wb_addr), 64'd1);
      wb_ready = 1'b1;
      step();
      step();
      in_valid = 1'b0;
      step();
      $display("txn back-pressure sequence done");
      chk("bp_write_count", 64'(wlog.size()), 64'd3);
      if (wlog.size() == 3) begin
         chk("bp_order_a", 64'(wlog[0]), {5'b0, 5'd1, 64'hA0A0});
         chk("bp_order_b", 64'(wlog[1]), {5'b0, 5'd2, 64'hB0B0});
         chk("bp_order_c", 64'(wlog[2]), {5'b0, 5'd3, 64'hC0C0});
      end

      // Compare (flags-only) entry
      n = wlog.size();
      drive(64'h0, 32'h0, 4'b0010, 5'd7, 1'b0);
      step();
      in_valid = 1'b0;
      chk("cmp_no_wb_valid", 64'(wb_valid), 64'd0);
      step();
      $display("txn compare entry retired");
      chk("cmp_status", 64'(status), 64'h0A);
      chk("cmp_no_write", 64'(wlog.size()), 64'(n));

      // Overflow flag entry, then overf-only entry with simultaneous clear
      drive(64'h0, 32'h0, 4'b1000, 5'd0, 1'b0);
      step();
      in_valid = 1'b0;
      step();
      chk("ovf1_status", 64'(status), 64'h18);
      chk("ovf1_count", 64'(ovf_count), 64'd1);
      drive(64'h9, 32'h1, 4'h0, 5'd4, 1'b1);
      step();
      in_valid = 1'b0;
      flag_clr = 1'b1;
      step();
      flag_clr = 1'b0;
      $display("txn overflow with flag_clr on pop");
      chk("setwins_status", 64'(status), 64'h18);
      chk("setwins_count", 64'(ovf_count), 64'd1);
      flag_clr = 1'b1;
      step();
      flag_clr = 1'b0;
      chk("clr_status", 64'(status), 64'h08);
      chk("clr_count", 64'(ovf_count), 64'd0);
      drive(64'h11, 32'h0, 4'b0100, 5'd5, 1'b1);
      step();
      in_valid = 1'b0;
      step();
      chk("parity_status", 64'(status), 64'h04);

      // Saturation of the overflow counter
      drive(64'h0, 32'h0, 4'b1000, 5'd0, 1'b0);
      for (int i = 1; i <= 65536; i++) begin
         step();
         if (i == 65535) chk("sat_fffe", 64'(ovf_count), 64'hFFFE);
         if (i == 65536) chk("sat_ffff", 64'(ovf_count), 64'hFFFF);
      end
      in_valid = 1'b0;
      step();
      $display("txn saturation run done");
      chk("sat_hold", 64'(ovf_count), 64'hFFFF);
      chk("sat_status", 64'(status), 64'h18);
      flag_clr = 1'b1;
      step();
      flag_clr = 1'b0;
      chk("sat_clr", 64'(ovf_count), 64'd0);
      chk("sat_clr_status", 64'(status), 64'h08);

      // Reset while FULL discards entries
      wlog.delete();
      wb_ready = 1'b0;
      drive(64'h77, 32'h0, 4'h0, 5'd8, 1'b1);
      step();
      drive(64'h88, 32'h0, 4'h0, 5'd9, 1'b1);
      step();
      in_valid = 1'b0;
      chk("full_in_ready", 64'(in_ready), 64'd0);
      reset_n = 1'b0;
      #1;
      chk("async_in_ready", 64'(in_ready), 64'd1);
      chk("async_wb_valid", 64'(wb_valid), 64'd0);
      chk("async_status", 64'(status), 64'h08);
      chk("async_wb_data", wb_data, 64'd0);
      wb_ready = 1'b1;
      step();
      step();
      reset_n = 1'b1;
      repeat (3) step();
      $display("txn reset while full");
      chk("post_rst_no_writes", 64'(wlog.size()), 64'd0);
      drive(64'h1234, 32'h0, 4'h0, 5'd6, 1'b1);
      step();
      in_valid = 1'b0;
      chk("post_rst_wb_valid", 64'(wb_valid), 64'd1);
      chk("post_rst_wb_data", wb_data, 64'h1234);
      step();
      chk("post_rst_write", 64'(wlog.size()), 64'd1);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_wb_stage.md
ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, execute stage presents a retiring ALU result.
REQ-004 SHALL have port in_ready, output, 1, stage accepts an entry this cycle.
REQ-005 SHALL have port in_result, input, 64, ALU result.
REQ-006 SHALL have port in_overf, input, 32, ALU overflow-extension word.
REQ-007 SHALL have port in_flags, input, 4, {Overflow, Parity_ODD, Compare, Zero} from the ALU.
REQ-008 SHALL have port in_dest, input, 5, destination register index.
REQ-009 SHALL have port in_wen, input, 1, entry writes the register file (0 = flags-only op, e.g. compare).
REQ-010 SHALL have port wb_valid, output, 1, register-file write request.
REQ-011 SHALL have port wb_ready, input, 1, register file accepts the write.
REQ-012 SHALL have port wb_data, output, 64, write data.
REQ-013 SHALL have port wb_addr, output, 5, write index.
REQ-014 SHALL have port flag_clr, input, 1, synchronous clear of sticky overflow and overflow counter.
REQ-015 SHALL have port status, output, 8, architectural status register.
REQ-016 SHALL have port ovf_count, output, 16, saturating count of retired overflowing entries.

Function
REQ-017 SHALL hold entries in a 2-entry FIFO (payload: result, overf, flags, dest, wen) with occupancy states EMPTY, ONE, FULL.
REQ-018 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in FULL, from registered state only (no combinational path from wb_ready).
REQ-019 SHALL push on in_valid & in_ready; SHALL ignore in_valid while in_ready = 0.
REQ-020 SHALL present the head entry at the output; an entry pushed into EMPTY appears the following cycle (1-cycle latency).
REQ-021 SHALL drive wb_valid = 1 only when occupancy > 0 and head wen = 1; wb_data/wb_addr = head result/dest.
REQ-022 SHALL pop the head when (head wen = 1 and wb_valid & wb_ready) or (head wen = 0, unconditionally that cycle).
REQ-023 Transitions: EMPTY-push->ONE; ONE-push-only->FULL; ONE-pop-only->EMPTY; ONE-push+pop->ONE; FULL-pop->ONE; otherwise hold.
REQ-024 SHALL preserve FIFO order; wb_data/wb_addr SHALL remain stable while wb_valid = 1 and wb_ready = 0.
REQ-025 SHALL update status only on pop, from the popped entry: [0] Zero, [1] Compare, [2] Parity_ODD, [3] ~Parity_ODD, [4] sticky overflow (OR-set), [7:5] = 0.
REQ-026 SHALL treat an entry as overflowing when flags Overflow = 1 or its overf != 0.
REQ-027 SHALL increment ovf_count on popping an overflowing entry, saturating at 16'hFFFF (no wrap).
REQ-028 flag_clr SHALL clear status[4] and ovf_count; if a pop of an overflowing entry occurs the same cycle, set wins: status[4] = 1, ovf_count = 1.
REQ-029 SHALL leave status[3:0] unchanged on flag_clr and in cycles without a pop.

Reset
REQ-030 On reset_n = 0 the stage SHALL asynchronously flush to EMPTY: in_ready = 1, wb_valid = 0, wb_data = 0, wb_addr = 0, status = 8'h08, ovf_count = 0.
REQ-031 Reset asserted mid-operation SHALL discard buffered entries without issuing any write; first push after release is accepted normally.

Verification
REQ-032 Push {result=64'h5, dest=3, wen=1, flags=0} with wb_ready=1 -> wb_valid high the next cycle with wb_data=5, wb_addr=3; after pop status=8'h08.
REQ-033 Hold wb_ready=0, push 3 back-to-back entries -> in_ready drops after 2nd accept, 3rd held off; release wb_ready -> writes in order A, B, then C.
REQ-034 Push compare entry {wen=0, flags Compare=1, Zero=0} -> no wb_valid pulse; one cycle later status[1]=1.
REQ-035 Push entry with overf=32'h1, flags Overflow=0, while asserting flag_clr on its pop cycle -> status[4]=1, ovf_count=1.
REQ-036 Force ovf_count to 16'hFFFF via 65535 overflowing pops, pop one more -> stays 16'hFFFF; flag_clr -> 0.
REQ-037 Fill to FULL with wb_ready=0, pulse reset_n low -> immediately in_ready=1, wb_valid=0, status=8'h08; no writes after release.
